// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA sync/colour timing generator
//
// Counts pixels and lines for any VGA-class mode, publishes the current
// coordinate (hpos/vpos/active plus line/frame strobes) to the colour source,
// and realigns sync, display-enable and the returned colour so that all leave
// on the same clock edge, PIPE_DLY+1 cycles after the coordinate was issued.
//
// Optional feature macro: VGA_TESTPAT_EN (adds test_en, 8-bar colour pattern).
//
// Ports:
//   clk25m       in   pixel clock
//   rst_n        in   synchronous active-low reset
//   rgb_in       in   colour for the coordinate issued PIPE_DLY cycles earlier
//   test_en      in   (VGA_TESTPAT_EN only) replace rgb_in with colour bars
//   hpos, vpos   out  current horizontal / vertical count
//   active       out  coordinate lies in the visible area (undelayed)
//   line_start   out  strobe while hpos==0
//   frame_start  out  strobe while hpos==0 and vpos==0
//   hs, vs, de   out  sync and display enable, aligned with rgb_out
//   rgb_out      out  registered colour to the pins, zero while blanked

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int H_POL    = 0,
    parameter int V_POL    = 0,
    parameter int CW       = 12,
    parameter int PIPE_DLY = 1
) (
    input  logic          clk25m,
    input  logic          rst_n,
    input  logic [CW-1:0] rgb_in,
`ifdef VGA_TESTPAT_EN
    input  logic          test_en,
`endif
    output logic [10:0]   hpos,
    output logic [10:0]   vpos,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] rgb_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
        $fatal(1, "vga_timing_gen: porch and sync widths must be >= 1");
    end
    if (H_TOTAL > 2047 || V_TOTAL > 2047) begin : g_bad_total
        $fatal(1, "vga_timing_gen: H_TOTAL and V_TOTAL must be <= 2047");
    end
    if (CW % 3 != 0 || CW < 3) begin : g_bad_cw
        $fatal(1, "vga_timing_gen: CW must be a positive multiple of 3");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $fatal(1, "vga_timing_gen: PIPE_DLY must be 0..7");
    end

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [10:0] hcnt;
    logic [10:0] vcnt;

    always_ff @(posedge clk25m) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 11'd0 : vcnt + 11'd1;
        end else begin
            hcnt <= hcnt + 11'd1;
        end
    end

    assign hpos        = hcnt;
    assign vpos        = vcnt;
    assign active      = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign line_start  = (hcnt == 11'd0);
    assign frame_start = (hcnt == 11'd0) && (vcnt == 11'd0);

    // Sync bits are carried as "asserted" flags; polarity is applied at the pin.
    logic hs_raw;
    logic vs_raw;
    assign hs_raw = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
    assign vs_raw = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);

    // Tap k of each line holds the value of the coordinate issued k cycles ago.
    // Tap PIPE_DLY gates the colour being sampled now; tap PIPE_DLY+1 is the
    // pin-side value, aligned with the registered rgb_out.
    logic [PIPE_DLY:0]   act_dly, hs_dly, vs_dly;
    logic [PIPE_DLY+1:0] act_tap, hs_tap, vs_tap;

    assign act_tap = {act_dly, active};
    assign hs_tap  = {hs_dly, hs_raw};
    assign vs_tap  = {vs_dly, vs_raw};

    always_ff @(posedge clk25m) begin
        if (!rst_n) begin
            act_dly <= '0;
            hs_dly  <= '0;
            vs_dly  <= '0;
        end else begin
            act_dly <= act_tap[PIPE_DLY:0];
            hs_dly  <= hs_tap[PIPE_DLY:0];
            vs_dly  <= vs_tap[PIPE_DLY:0];
        end
    end

    assign de = act_tap[PIPE_DLY+1];
    assign hs = (H_POL != 0) ? hs_tap[PIPE_DLY+1] : ~hs_tap[PIPE_DLY+1];
    assign vs = (V_POL != 0) ? vs_tap[PIPE_DLY+1] : ~vs_tap[PIPE_DLY+1];

    logic [CW-1:0] pix_src;

`ifdef VGA_TESTPAT_EN
    localparam int CC    = CW / 3;
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    // hcnt delayed to line up with rgb_in, so bars share normal-mode alignment.
    logic [10:0] h_pix;
    if (PIPE_DLY == 0) begin : g_hpix_now
        assign h_pix = hcnt;
    end else begin : g_hpix_dly
        logic [PIPE_DLY-1:0][10:0] h_dly;
        always_ff @(posedge clk25m) begin
            h_dly[0] <= hcnt;
            for (int i = 1; i < PIPE_DLY; i++) begin
                h_dly[i] <= h_dly[i-1];
            end
        end
        assign h_pix = h_dly[PIPE_DLY-1];
    end

    logic [10:0] bar_raw;
    logic [2:0]  bar;
    logic [CW-1:0] bar_col;
    assign bar_raw = h_pix / 11'(BAR_W);
    assign bar     = (bar_raw > 11'd7) ? 3'd7 : bar_raw[2:0];
    // Bar order white, yellow, cyan, green, magenta, red, blue, black.
    assign bar_col = {{CC{~bar[1]}}, {CC{~bar[2]}}, {CC{~bar[0]}}};
    assign pix_src = test_en ? bar_col : rgb_in;
`else
    assign pix_src = rgb_in;
`endif

    always_ff @(posedge clk25m) begin
        if (!rst_n) begin
            rgb_out <= '0;
        end else begin
            rgb_out <= act_tap[PIPE_DLY] ? pix_src : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen (small mode)

module tb_vga_timing_gen;

    localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 6,  VF = 1, VSW = 2, VB = 1;
    localparam int HT = 24, VT = 10, FT = 240;
    localparam int PD = 2;
    localparam int LAT = PD + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] rgb_in;
    logic [10:0] hpos, vpos;
    logic        active, line_start, frame_start, hs, vs, de;
    logic [11:0] rgb_out;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .H_POL(0), .V_POL(1), .CW(12), .PIPE_DLY(PD)
    ) dut (
        .clk25m(clk), .rst_n(rst_n), .rgb_in(rgb_in),
        .hpos(hpos), .vpos(vpos), .active(active),
        .line_start(line_start), .frame_start(frame_start),
        .hs(hs), .vs(vs), .de(de), .rgb_out(rgb_out)
    );

    // Colour source tag for the coordinate of cycle c: {vpos[3:0], hpos[7:0]}.
    function automatic logic [11:0] code_of(input int c);
        int h, v;
        if (c < 0) return 12'h000;
        h = c % HT;
        v = (c / HT) % VT;
        return {v[3:0], h[7:0]};
    endfunction

    // Advance one cycle; rgb_in follows the coordinate issued PD cycles ago.
    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        rgb_in = code_of(cyc - PD);
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rgb_in = 12'hABC;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (hpos !== 11'd0)     begin failures++; $display("FAIL reset_hpos got=%0d exp=0", hpos); end
        checks++; if (vpos !== 11'd0)     begin failures++; $display("FAIL reset_vpos got=%0d exp=0", vpos); end
        checks++; if (active !== 1'b1)    begin failures++; $display("FAIL reset_active got=%b exp=1", active); end
        checks++; if (line_start !== 1'b1) begin failures++; $display("FAIL reset_line_start got=%b exp=1", line_start); end
        checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL reset_frame_start got=%b exp=1", frame_start); end
        checks++; if (hs !== 1'b1)        begin failures++; $display("FAIL reset_hs got=%b exp=1", hs); end
        checks++; if (vs !== 1'b0)        begin failures++; $display("FAIL reset_vs got=%b exp=0", vs); end
        checks++; if (de !== 1'b0)        begin failures++; $display("FAIL reset_de got=%b exp=0", de); end
        checks++; if (rgb_out !== 12'h000) begin failures++; $display("FAIL reset_rgb got=%h exp=000", rgb_out); end
        rst_n = 1'b1;
        cyc = 0;
        rgb_in = code_of(-PD);
    endtask

    // Two full frames compared cycle by cycle against a timing model, plus
    // aggregate pulse counts.
    task automatic test_frames();
        int hs_low = 0, vs_high = 0, de_cnt = 0, fs_cnt = 0;
        int first_hs_low = -1, second_hs_low = -1;
        logic prev_hs = 1'b1;
        for (int c = 0; c < 2 * FT; c++) begin
            int p, ph, pv;
            logic e_hs, e_vs, e_de;
            logic [11:0] e_rgb;
            p = c - LAT;
            if (p < 0) begin
                e_hs = 1'b1; e_vs = 1'b0; e_de = 1'b0; e_rgb = 12'h000;
            end else begin
                ph = p % HT;
                pv = (p / HT) % VT;
                e_de  = (ph < HA) && (pv < VA);
                e_hs  = (ph >= HA + HF && ph <= HA + HF + HSW - 1) ? 1'b0 : 1'b1;
                e_vs  = (pv >= VA + VF && pv <= VA + VF + VSW - 1) ? 1'b1 : 1'b0;
                e_rgb = e_de ? code_of(p) : 12'h000;
            end
            checks++; if (hpos !== 11'(c % HT)) begin failures++; $display("FAIL frm_hpos c=%0d got=%0d exp=%0d", c, hpos, c % HT); end
            checks++; if (vpos !== 11'((c / HT) % VT)) begin failures++; $display("FAIL frm_vpos c=%0d got=%0d exp=%0d", c, vpos, (c / HT) % VT); end
            checks++; if (active !== ((c % HT) < HA && ((c / HT) % VT) < VA)) begin failures++; $display("FAIL frm_active c=%0d got=%b", c, active); end
            checks++; if (line_start !== (c % HT == 0)) begin failures++; $display("FAIL frm_line_start c=%0d got=%b", c, line_start); end
            checks++; if (frame_start !== (c % FT == 0)) begin failures++; $display("FAIL frm_frame_start c=%0d got=%b", c, frame_start); end
            checks++; if (hs !== e_hs) begin failures++; $display("FAIL frm_hs c=%0d got=%b exp=%b", c, hs, e_hs); end
            checks++; if (vs !== e_vs) begin failures++; $display("FAIL frm_vs c=%0d got=%b exp=%b", c, vs, e_vs); end
            checks++; if (de !== e_de) begin failures++; $display("FAIL frm_de c=%0d got=%b exp=%b", c, de, e_de); end
            checks++; if (rgb_out !== e_rgb) begin failures++; $display("FAIL frm_rgb c=%0d got=%h exp=%h", c, rgb_out, e_rgb); end
            if (hs === 1'b0) hs_low++;
            if (vs === 1'b1) vs_high++;
            if (de === 1'b1) de_cnt++;
            if (frame_start === 1'b1) fs_cnt++;
            if (prev_hs === 1'b1 && hs === 1'b0) begin
                if (first_hs_low < 0) first_hs_low = c;
                else if (second_hs_low < 0) second_hs_low = c;
            end
            prev_hs = hs;
            step();
        end
        checks++; if (hs_low != 60)  begin failures++; $display("FAIL cnt_hs_low got=%0d exp=60", hs_low); end
        checks++; if (vs_high != 96) begin failures++; $display("FAIL cnt_vs_high got=%0d exp=96", vs_high); end
        checks++; if (de_cnt != 192) begin failures++; $display("FAIL cnt_de got=%0d exp=192", de_cnt); end
        checks++; if (fs_cnt != 2)   begin failures++; $display("FAIL cnt_frame_start got=%0d exp=2", fs_cnt); end
        checks++; if (first_hs_low != 21) begin failures++; $display("FAIL hs_first_edge got=%0d exp=21", first_hs_low); end
        checks++; if (second_hs_low != 45) begin failures++; $display("FAIL hs_line_period got=%0d exp=45", second_hs_low); end
    endtask

    // Hand-picked pixels of the third frame (starts at cycle 480).
    task automatic test_pixel_edges();
        run_to(483);
        checks++; if (de !== 1'b1 || rgb_out !== 12'h000) begin failures++; $display("FAIL pix_first de=%b rgb=%h exp de=1 rgb=000", de, rgb_out); end
        run_to(498);
        checks++; if (de !== 1'b1 || rgb_out !== 12'h00F) begin failures++; $display("FAIL pix_last de=%b rgb=%h exp de=1 rgb=00f", de, rgb_out); end
        run_to(499);
        checks++; if (de !== 1'b0 || rgb_out !== 12'h000) begin failures++; $display("FAIL pix_blank de=%b rgb=%h exp de=0 rgb=000", de, rgb_out); end
        run_to(500);
        checks++; if (hs !== 1'b1) begin failures++; $display("FAIL hs_before got=%b exp=1", hs); end
        run_to(501);
        checks++; if (hs !== 1'b0) begin failures++; $display("FAIL hs_start got=%b exp=0", hs); end
        run_to(503);
        checks++; if (hs !== 1'b0) begin failures++; $display("FAIL hs_end got=%b exp=0", hs); end
        run_to(504);
        checks++; if (hs !== 1'b1) begin failures++; $display("FAIL hs_after got=%b exp=1", hs); end
        run_to(507);
        checks++; if (de !== 1'b1 || rgb_out !== 12'h100) begin failures++; $display("FAIL pix_line1 de=%b rgb=%h exp de=1 rgb=100", de, rgb_out); end
    endtask

    task automatic test_wrap();
        run_to(719);
        checks++; if (hpos !== 11'd23 || vpos !== 11'd9) begin failures++; $display("FAIL wrap_last h=%0d v=%0d exp 23,9", hpos, vpos); end
        checks++; if (line_start !== 1'b0 || frame_start !== 1'b0) begin failures++; $display("FAIL wrap_last_strobes ls=%b fs=%b exp 0,0", line_start, frame_start); end
        run_to(720);
        checks++; if (hpos !== 11'd0 || vpos !== 11'd0) begin failures++; $display("FAIL wrap_zero h=%0d v=%0d exp 0,0", hpos, vpos); end
        checks++; if (line_start !== 1'b1 || frame_start !== 1'b1) begin failures++; $display("FAIL wrap_zero_strobes ls=%b fs=%b exp 1,1", line_start, frame_start); end
        run_to(744);
        checks++; if (hpos !== 11'd0 || vpos !== 11'd1 || line_start !== 1'b1 || frame_start !== 1'b0) begin
            failures++; $display("FAIL wrap_line h=%0d v=%0d ls=%b fs=%b exp 0,1,1,0", hpos, vpos, line_start, frame_start);
        end
    endtask

    // Reset while both syncs are asserted at the pins; nothing may be stretched.
    task automatic test_midframe_reset();
        run_to(910);
        checks++; if (hs !== 1'b0 || vs !== 1'b1) begin failures++; $display("FAIL pre_reset_sync hs=%b vs=%b exp 0,1", hs, vs); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        rgb_in = code_of(-PD);
        checks++; if (hpos !== 11'd0 || vpos !== 11'd0 || frame_start !== 1'b1) begin
            failures++; $display("FAIL rst_mid_pos h=%0d v=%0d fs=%b exp 0,0,1", hpos, vpos, frame_start);
        end
        for (int c = 0; c < LAT; c++) begin
            checks++; if (hs !== 1'b1 || vs !== 1'b0 || de !== 1'b0 || rgb_out !== 12'h000) begin
                failures++; $display("FAIL rst_mid_refill c=%0d hs=%b vs=%b de=%b rgb=%h exp 1,0,0,000", c, hs, vs, de, rgb_out);
            end
            checks++; if (hpos !== 11'(c)) begin failures++; $display("FAIL rst_mid_hpos c=%0d got=%0d exp=%0d", c, hpos, c); end
            step();
        end
        checks++; if (de !== 1'b1 || rgb_out !== 12'h000 || hs !== 1'b1 || vs !== 1'b0) begin
            failures++; $display("FAIL rst_mid_first_pix de=%b rgb=%h hs=%b vs=%b exp 1,000,1,0", de, rgb_out, hs, vs);
        end
        run_to(4);
        checks++; if (rgb_out !== 12'h001) begin failures++; $display("FAIL rst_mid_second_pix got=%h exp=001", rgb_out); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        rgb_in = 12'h000;
        test_reset();
        test_frames();
        test_pixel_edges();
        test_wrap();
        test_midframe_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 sync/colour path.
- Generates horizontal and vertical counters, sync pulses with programmable polarity, display-enable and frame/line strobes for any VGA-class mode.
- Publishes the current pixel coordinate to the colour/sprite logic, accepts that logic's colour PIPE_DLY cycles later, and realigns sync and colour so both leave on the same cycle.
- Sits between the pixel clock and the VGA pins; replaces the separate pixel-counter and sync blocks.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync asserted level (0 = active low)
V_POL, 0, vsync asserted level (0 = active low)
CW, 12, colour width ({r,g,b}, CW/3 bits each)
PIPE_DLY, 1, colour-source latency in cycles from hpos/vpos to rgb_in (0..7)

Ports:
clk25m  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
rgb_in  in  CW  colour for the coordinate issued PIPE_DLY cycles earlier
hpos  out  11  current horizontal count (combinational from count register)
vpos  out  11  current vertical count
active  out  1  hpos<H_ACTIVE and vpos<V_ACTIVE (undelayed, aligned with hpos/vpos)
line_start  out  1  one-cycle strobe, hpos==0
frame_start  out  1  one-cycle strobe, hpos==0 and vpos==0
hs  out  1  horizontal sync (aligned with rgb_out)
vs  out  1  vertical sync (aligned with rgb_out)
de  out  1  display enable (aligned with rgb_out)
rgb_out  out  CW  registered colour to pins

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined likewise.
- hcnt advances every cycle. It wraps from H_TOTAL-1 to 0.
- vcnt increments only on the hcnt wrap. It wraps from V_TOTAL-1 to 0.
- Counters are 11 bits unsigned; the upper bits read 0 for the default mode.
- hsync_raw is asserted while H_ACTIVE+H_FP <= hcnt <= H_ACTIVE+H_FP+H_SYNC-1.
- vsync_raw is asserted on the same rule for vcnt, independent of hcnt. The vertical edge coincides with hcnt==0.
- Asserted level is H_POL / V_POL; the deasserted level is the inverse.
- Alignment:
  - A coordinate is presented at cycle N.
  - rgb_in for it is sampled at N+PIPE_DLY.
  - rgb_out, hs, vs and de for it appear at N+PIPE_DLY+1.
  - hs, vs and active therefore pass through a PIPE_DLY+1 stage delay line.
- rgb_out = rgb_in when the delayed active bit is 1, else all zeros. Blanking is forced regardless of rgb_in.
- Reset (rst_n low at a rising edge):
  - hcnt, vcnt = 0.
  - Every delay-line stage is set to deasserted sync and de=0.
  - rgb_out = 0; hs = ~H_POL, vs = ~V_POL, de = 0.
  - hpos, vpos = 0; active = 1; line_start and frame_start assert on the first cycle after release.
- Reset mid-frame restarts at (0,0) on the next edge. No partial sync pulse is stretched, because the delay line is cleared.
- With hpos==H_TOTAL-1 and vpos==V_TOTAL-1, the next cycle is (0,0) with both strobes high.
- Parameter legality, checked at elaboration (a violation stops elaboration):
  - every porch and sync width >= 1;
  - H_TOTAL, V_TOTAL <= 2047;
  - CW a multiple of 3.

Optional Feature:
Macro: VGA_TESTPAT_EN
- Defined:
  - Adds input port test_en (1 bit).
  - While test_en is 1, rgb_in is ignored. rgb_out shows 8 vertical colour bars, each H_ACTIVE/8 pixels wide, in the order white, yellow, cyan, green, magenta, red, blue, black.
  - Bar colours are full-scale per channel.
  - The bar pattern is generated from the delayed hcnt, so its alignment and blanking match normal mode.
  - test_en is sampled per pixel; toggling mid-line switches at that pixel.
- Undefined:
  - No test_en port.
  - rgb_out always follows rgb_in.

Test Plan:
- Defaults, release reset, run 2 frames -> hs low for exactly 96 cycles starting when hpos==656 was issued 2 cycles earlier; line period 800 cycles; vs low for 2 lines (vpos 490-491); frame period 420000 cycles.
- Defaults, rgb_in=12'hFFF constant -> rgb_out=FFF with de=1 for 640 cycles per visible line; rgb_out=000 otherwise, including lines 480-524.
- PIPE_DLY=3, rgb_in fed with hpos[11:0] delayed 3 cycles -> on every de=1 cycle rgb_out equals the pixel index; first visible pixel shows 0, last shows 639.
- H_POL=1, V_POL=1, mode 800x600 (40/128/88, 1/4/23) -> hs high for 128 cycles per 1056-cycle line; vs high for 4 lines per 628-line frame; frame_start every 663168 cycles.
- Assert rst_n=0 for 1 cycle at hpos=700, vpos=200 -> next cycle hpos=0, vpos=0, frame_start=1; hs/vs deasserted and de=0 until the delay line refills.
- VGA_TESTPAT_EN defined, test_en=1 -> pixels 0-79 give FFF, 80-159 FF0, ..., 560-639 000; blanking still 000.
